mem_rd_arbiter: RTL and testbench

//  Shares one AXI-lite read port to memory between instruction fetch (port 0) and the

---
 rtl/mem_rd_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter.sv
// Two-master to one-slave AXI-lite read arbiter, one outstanding read, with IF-response drop on flush.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin on contention; default is fixed priority (s1 wins).
module mem_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_s0_arvalid,
  output logic              o_s0_arready,
  input  logic [ADDR_W-1:0] i_s0_araddr,
  output logic              o_s0_rvalid,
  input  logic              i_s0_rready,
  output logic [DATA_W-1:0] o_s0_rdata,
  output logic [1:0]        o_s0_rresp,
  input  logic              i_s1_arvalid,
  output logic              o_s1_arready,
  input  logic [ADDR_W-1:0] i_s1_araddr,
  output logic              o_s1_rvalid,
  input  logic              i_s1_rready,
  output logic [DATA_W-1:0] o_s1_rdata,
  output logic [1:0]        o_s1_rresp,
  output logic              o_m_arvalid,
  input  logic              i_m_arready,
  output logic [ADDR_W-1:0] o_m_araddr,
  input  logic              i_m_rvalid,
  output logic              o_m_rready,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic [1:0]        i_m_rresp,
  input  logic              i_flush_if,
  output logic [1:0]        o_grant
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic [1:0]          r_grant;
  logic                r_drop;
  logic [ADDR_W-1:0]   r_araddr;
  logic                w_req0;
  logic                w_req1;
  logic                w_win0;
  logic                w_win1;
  logic                w_drop;
  logic                w_m_rready;

  // A flushed fetch may not even enter arbitration this cycle.
  assign w_req0 = i_s0_arvalid && !i_flush_if && (r_state == ST_IDLE) && !rst;
  assign w_req1 = i_s1_arvalid && (r_state == ST_IDLE) && !rst;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_s1;

  assign w_win1 = w_req1 && (!w_req0 || !r_last_s1);

  always_ff @(posedge clk) begin
    if (rst)
      r_last_s1 <= 1'b1;
    else if (w_req0 && w_req1)
      r_last_s1 <= w_win1;
  end
`else
  assign w_win1 = w_req1;
`endif

  assign w_win0 = w_req0 && !w_win1;

  // The drop takes effect in the flush cycle itself, not only once registered.
  assign w_drop     = !r_owner && (r_drop || i_flush_if);
  assign w_m_rready = r_owner ? i_s1_rready : (i_s0_rready || w_drop);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_win0 || w_win1) w_next = ST_ADDR;
      ST_ADDR: if (i_m_arready) w_next = ST_DATA;
      ST_DATA: if (i_m_rvalid && w_m_rready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_s0_arready = 1'b0;
    o_s1_arready = 1'b0;
    o_s0_rvalid  = 1'b0;
    o_s1_rvalid  = 1'b0;
    o_m_arvalid  = 1'b0;
    o_m_rready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_s0_arready = w_win0;
        o_s1_arready = w_win1;
      end
      ST_ADDR: o_m_arvalid = 1'b1;
      ST_DATA: begin
        o_m_rready  = w_m_rready;
        o_s0_rvalid = !r_owner && !w_drop && i_m_rvalid;
        o_s1_rvalid = r_owner && i_m_rvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_grant <= 2'b00;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_drop <= 1'b0;
          if (w_win0 || w_win1) begin
            r_owner <= w_win1;
            r_grant <= {w_win1, w_win0};
          end
        end
        ST_ADDR: if (i_flush_if && !r_owner) r_drop <= 1'b1;
        ST_DATA: begin
          if (i_flush_if && !r_owner) r_drop <= 1'b1;
          if (i_m_rvalid && w_m_rready) begin
            r_grant <= 2'b00;
            r_drop  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_win0)
      r_araddr <= i_s0_araddr;
    else if (w_win1)
      r_araddr <= i_s1_araddr;
  end

  assign o_m_araddr = r_araddr;
  assign o_grant    = r_grant;
  assign o_s0_rdata = i_m_rdata;
  assign o_s1_rdata = i_m_rdata;
  assign o_s0_rresp = i_m_rresp;
  assign o_s1_rresp = i_m_rresp;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter; the bench plays the memory controller on the m side.
module tb_mem_rd_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_s0_arvalid = 1'b0, i_s1_arvalid = 1'b0;
  logic [63:0] i_s0_araddr = '0, i_s1_araddr = '0;
  logic        i_s0_rready = 1'b0, i_s1_rready = 1'b0;
  logic        i_m_arready = 1'b0, i_m_rvalid = 1'b0;
  logic [31:0] i_m_rdata = '0;
  logic [1:0]  i_m_rresp = 2'b00;
  logic        i_flush_if = 1'b0;
  logic        o_s0_arready, o_s1_arready, o_s0_rvalid, o_s1_rvalid;
  logic [31:0] o_s0_rdata, o_s1_rdata;
  logic [1:0]  o_s0_rresp, o_s1_rresp;
  logic        o_m_arvalid, o_m_rready;
  logic [63:0] o_m_araddr;
  logic [1:0]  o_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.ADDR_W(64), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_s0_arvalid(i_s0_arvalid), .o_s0_arready(o_s0_arready), .i_s0_araddr(i_s0_araddr),
    .o_s0_rvalid(o_s0_rvalid), .i_s0_rready(i_s0_rready), .o_s0_rdata(o_s0_rdata),
    .o_s0_rresp(o_s0_rresp),
    .i_s1_arvalid(i_s1_arvalid), .o_s1_arready(o_s1_arready), .i_s1_araddr(i_s1_araddr),
    .o_s1_rvalid(o_s1_rvalid), .i_s1_rready(i_s1_rready), .o_s1_rdata(o_s1_rdata),
    .o_s1_rresp(o_s1_rresp),
    .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready), .o_m_araddr(o_m_araddr),
    .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready), .i_m_rdata(i_m_rdata),
    .i_m_rresp(i_m_rresp), .i_flush_if(i_flush_if), .o_grant(o_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after acceptance (FSM in ADDR); completes AR and one R beat, ends back in IDLE.
  task automatic run_txn(input logic [31:0] rd, output logic [63:0] addr, output logic [1:0] gnt,
                         output logic v0, output logic v1, output logic [31:0] d0,
                         output logic [31:0] d1);
    addr = o_m_araddr;
    gnt  = o_grant;
    i_m_arready = 1'b1;
    tick();
    i_m_arready = 1'b0;
    i_m_rvalid  = 1'b1;
    i_m_rdata   = rd;
    i_s0_rready = 1'b1;
    i_s1_rready = 1'b1;
    #1;
    v0 = o_s0_rvalid;
    v1 = o_s1_rvalid;
    d0 = o_s0_rdata;
    d1 = o_s1_rdata;
    tick();
    i_m_rvalid  = 1'b0;
    i_s0_rready = 1'b0;
    i_s1_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_s0_arvalid = 1'b1;
    i_s1_arvalid = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_m_arvalid, o_m_rready, o_s0_arready, o_s1_arready, o_s0_rvalid, o_s1_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000",
               {o_m_arvalid, o_m_rready, o_s0_arready, o_s1_arready, o_s0_rvalid, o_s1_rvalid});
    end
    checks++;
    if (o_grant !== 2'b00) begin
      errors++;
      $display("FAIL reset_grant: got %b want 00", o_grant);
    end
    i_s0_arvalid = 1'b0;
    i_s1_arvalid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_s0_single();
    logic [63:0] a; logic [1:0] g; logic v0, v1; logic [31:0] d0, d1;
    i_s0_arvalid = 1'b1;
    i_s0_araddr  = 64'h1000;
    #1;
    checks++;
    if ({o_s0_arready, o_s1_arready} !== 2'b10) begin
      errors++;
      $display("FAIL t1_arready: got s0=%b s1=%b want s0=1 s1=0", o_s0_arready, o_s1_arready);
    end
    tick();
    i_s0_arvalid = 1'b0;
    checks++;
    if (o_m_arvalid !== 1'b1 || o_m_araddr !== 64'h1000) begin
      errors++;
      $display("FAIL t1_ar: got arvalid=%b araddr=%h want 1/1000", o_m_arvalid, o_m_araddr);
    end
    run_txn(32'h0000_0013, a, g, v0, v1, d0, d1);
    checks++;
    if (g !== 2'b01) begin
      errors++;
      $display("FAIL t1_grant: got %b want 01", g);
    end
    checks++;
    if (v0 !== 1'b1 || v1 !== 1'b0 || d0 !== 32'h13) begin
      errors++;
      $display("FAIL t1_resp: got v0=%b v1=%b d0=%h want 1/0/00000013", v0, v1, d0);
    end
    checks++;
    if (o_grant !== 2'b00 || o_m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle: got grant=%b arvalid=%b want 00/0", o_grant, o_m_arvalid);
    end
  endtask

  task automatic test_contention();
    logic [63:0] a; logic [1:0] g; logic v0, v1; logic [31:0] d0, d1;
    logic first1;
    first1 = !RR;
    i_s0_arvalid = 1'b1; i_s0_araddr = 64'h2000;
    i_s1_arvalid = 1'b1; i_s1_araddr = 64'h8000;
    #1;
    checks++;
    if (o_s1_arready !== first1 || o_s0_arready !== !first1) begin
      errors++;
      $display("FAIL t2_arb: got s0=%b s1=%b want s1=%b", o_s0_arready, o_s1_arready, first1);
    end
    tick();
    if (first1) i_s1_arvalid = 1'b0; else i_s0_arvalid = 1'b0;
    checks++;
    if (o_s0_arready !== 1'b0 || o_s1_arready !== 1'b0) begin
      errors++;
      $display("FAIL t2_busy_arready: got s0=%b s1=%b want 0/0", o_s0_arready, o_s1_arready);
    end
    run_txn(32'hAAAA_0001, a, g, v0, v1, d0, d1);
    checks++;
    if (first1 ? (a !== 64'h8000 || g !== 2'b10 || v1 !== 1'b1 || v0 !== 1'b0 || d1 !== 32'hAAAA_0001)
               : (a !== 64'h2000 || g !== 2'b01 || v0 !== 1'b1 || v1 !== 1'b0 || d0 !== 32'hAAAA_0001)) begin
      errors++;
      $display("FAIL t2_first: got addr=%h grant=%b v0=%b v1=%b d0=%h d1=%h", a, g, v0, v1, d0, d1);
    end
    checks++;
    if ((first1 ? o_s0_arready : o_s1_arready) !== 1'b1) begin
      errors++;
      $display("FAIL t2_second_accept: got s0=%b s1=%b", o_s0_arready, o_s1_arready);
    end
    tick();
    i_s0_arvalid = 1'b0;
    i_s1_arvalid = 1'b0;
    run_txn(32'h5555_0002, a, g, v0, v1, d0, d1);
    checks++;
    if (first1 ? (a !== 64'h2000 || g !== 2'b01 || v0 !== 1'b1 || v1 !== 1'b0 || d0 !== 32'h5555_0002)
               : (a !== 64'h8000 || g !== 2'b10 || v1 !== 1'b1 || v0 !== 1'b0 || d1 !== 32'h5555_0002)) begin
      errors++;
      $display("FAIL t2_second: got addr=%h grant=%b v0=%b v1=%b d0=%h d1=%h", a, g, v0, v1, d0, d1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a; logic [1:0] g; logic v0, v1; logic [31:0] d0, d1;
    logic [1:0] exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_s0_arvalid = 1'b1; i_s0_araddr = 64'h100;
    i_s1_arvalid = 1'b1; i_s1_araddr = 64'h200;
    for (int i = 0; i < 6; i++) begin
      tick();
      run_txn(32'hB000_0000 + 32'(i), a, g, v0, v1, d0, d1);
      exp_g = RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
      checks++;
      if (g !== exp_g || a !== ((exp_g == 2'b01) ? 64'h100 : 64'h200)) begin
        errors++;
        $display("FAIL t3_seq[%0d]: got grant=%b addr=%h want grant=%b", i, g, a, exp_g);
      end
    end
    i_s0_arvalid = 1'b0;
    i_s1_arvalid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [63:0] a; logic [1:0] g; logic v0, v1; logic [31:0] d0, d1;
    logic seen;
    i_s0_arvalid = 1'b1; i_s0_araddr = 64'h3000;
    tick();
    i_s0_arvalid = 1'b0;
    i_m_arready = 1'b1;
    tick();
    i_m_arready = 1'b0;
    i_flush_if = 1'b1;
    tick();
    i_flush_if = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seen |= o_s0_rvalid;
      tick();
    end
    i_m_rvalid = 1'b1;
    i_m_rdata  = 32'hDEAD_BEEF;
    #1;
    seen |= o_s0_rvalid;
    checks++;
    if (o_m_rready !== 1'b1 || seen !== 1'b0) begin
      errors++;
      $display("FAIL t4_drop: got m_rready=%b s0_rvalid_seen=%b want 1/0", o_m_rready, seen);
    end
    tick();
    i_m_rvalid = 1'b0;
    checks++;
    if (o_grant !== 2'b00 || o_m_arvalid !== 1'b0 || o_s0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL t4_idle: got grant=%b arvalid=%b want 00/0", o_grant, o_m_arvalid);
    end
    i_s0_arvalid = 1'b1; i_s0_araddr = 64'h3100;
    i_flush_if = 1'b1;
    #1;
    checks++;
    if (o_s0_arready !== 1'b0) begin
      errors++;
      $display("FAIL t4_idle_mask: got s0_arready=%b want 0", o_s0_arready);
    end
    i_flush_if = 1'b0;
    #1;
    tick();
    i_s0_arvalid = 1'b0;
    run_txn(32'h0BAD_F00D, a, g, v0, v1, d0, d1);
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'h0BAD_F00D || a !== 64'h3100) begin
      errors++;
      $display("FAIL t4_after: got v0=%b d0=%h addr=%h want 1/0badf00d/3100", v0, d0, a);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a; logic [1:0] g; logic v0, v1; logic [31:0] d0, d1;
    i_s0_arvalid = 1'b1; i_s0_araddr = 64'h5000;
    tick();
    i_s0_arvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (o_m_arvalid !== 1'b0 || o_grant !== 2'b00) begin
      errors++;
      $display("FAIL t5_reset: got arvalid=%b grant=%b want 0/00", o_m_arvalid, o_grant);
    end
    i_s1_arvalid = 1'b1; i_s1_araddr = 64'h6000;
    #1;
    checks++;
    if (o_s1_arready !== 1'b1) begin
      errors++;
      $display("FAIL t5_accept: got s1_arready=%b want 1", o_s1_arready);
    end
    tick();
    i_s1_arvalid = 1'b0;
    run_txn(32'h1234_5678, a, g, v0, v1, d0, d1);
    checks++;
    if (a !== 64'h6000 || g !== 2'b10 || v1 !== 1'b1 || v0 !== 1'b0 || d1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL t5_txn: got addr=%h grant=%b v0=%b v1=%b d1=%h", a, g, v0, v1, d1);
    end
  endtask

  task automatic test_ar_stall();
    logic [63:0] a; logic [1:0] g; logic v0, v1; logic [31:0] d0, d1;
    i_s1_arvalid = 1'b1; i_s1_araddr = 64'hC0DE_0000;
    tick();
    i_s1_araddr = 64'h7777;
    i_s0_arvalid = 1'b1; i_s0_araddr = 64'h4000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_m_arvalid !== 1'b1 || o_m_araddr !== 64'hC0DE_0000 ||
          o_s0_arready !== 1'b0 || o_s1_arready !== 1'b0) begin
        errors++;
        $display("FAIL t6_stall[%0d]: got arvalid=%b araddr=%h s0_ar=%b s1_ar=%b",
                 i, o_m_arvalid, o_m_araddr, o_s0_arready, o_s1_arready);
      end
      tick();
    end
    i_s0_arvalid = 1'b0;
    i_s1_arvalid = 1'b0;
    run_txn(32'hFEED_0006, a, g, v0, v1, d0, d1);
    checks++;
    if (v1 !== 1'b1 || v0 !== 1'b0 || d1 !== 32'hFEED_0006 || g !== 2'b10) begin
      errors++;
      $display("FAIL t6_txn: got v0=%b v1=%b d1=%h grant=%b", v0, v1, d1, g);
    end
  endtask

  initial begin
    test_reset();
    test_s0_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_ar_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
